// File: rtl/mx11_pkg.sv
// mx11_pkg: shared types and constants for the mx11 instruction decoder.
//   dec_state_t  - decoder FSM state encoding
//   IP_REG_IDX   - register-bus index holding the instruction pointer
//   LEN_*        - position and illegal value of the immediate-count field
//                  in the opcode byte
package mx11_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_OP,
    FETCH_IMM,
    SETTLE,
    ISSUE,
    DRAIN,
    TRAP
  } dec_state_t;

  localparam logic [3:0]  IP_REG_IDX  = 4'h7;
  localparam int unsigned LEN_MSB     = 7;
  localparam int unsigned LEN_LSB     = 6;
  localparam logic [1:0]  LEN_ILLEGAL = 2'd3;

endpackage

// File: rtl/mx11_ins_decode_reg_tap.sv
// reg_tap: selects one DATA_WIDTH register from the flattened register bus.
//   reg_line in  REGBUS_WIDTH*DATA_WIDTH  flattened register bus, reg 0 in LSBs
//   idx      in  4                        register index
//   data     out DATA_WIDTH               selected register value
module reg_tap #(
  parameter int unsigned REGBUS_WIDTH = 16,
  parameter int unsigned DATA_WIDTH   = 8
) (
  input  logic [REGBUS_WIDTH*DATA_WIDTH-1:0] reg_line,
  input  logic [3:0]                         idx,
  output logic [DATA_WIDTH-1:0]              data
);

  always_comb begin
    data = '0;
    for (int unsigned i = 0; i < REGBUS_WIDTH; i++) begin
      if (idx == i[3:0]) begin
        data = reg_line[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: rtl/mx11_ins_decode.sv
// mx11_ins_decode: sequences instruction-byte fetches, assembles 1-3 byte
// instructions (opcode + 0..2 immediates), bumps the IP after every fetched
// byte and hands the decoded instruction to execute over valid/ready.
//   clk, rst (async, active-low)
//   reg_line          register bus, IP read at index 7
//   run, flush        level run control / abandon-instruction pulse
//   fetch, insr, load_en   fetch request, fetched byte, byte strobe
//   ip_we, ip_wdata   IP write strobe and IP+1
//   op_valid, op_ready, op_code, op_len, op_imm, op_trap   issue interface
// Optional feature macro: MX11_ILLEGAL_TRAP_EN (len=3 opcodes trap instead of
// being treated as len=2).
module mx11_ins_decode
  import mx11_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned REGBUS_WIDTH = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [REGBUS_WIDTH*DATA_WIDTH-1:0] reg_line,
  input  logic                               run,
  input  logic                               flush,
  output logic                               fetch,
  input  logic [DATA_WIDTH-1:0]              insr,
  input  logic                               load_en,
  output logic                               ip_we,
  output logic [DATA_WIDTH-1:0]              ip_wdata,
  output logic                               op_valid,
  input  logic                               op_ready,
  output logic [5:0]                         op_code,
  output logic [1:0]                         op_len,
  output logic [2*DATA_WIDTH-1:0]            op_imm,
  output logic                               op_trap
);

  // ADDR_WIDTH describes the fetch-side bus only; nothing here depends on it.
  if (ADDR_WIDTH == 0) begin : g_addr_width_unused
  end

  dec_state_t              state_q, state_d;
  logic [5:0]              op_code_q, op_code_d;
  logic [1:0]              op_len_q, op_len_d;
  logic [2*DATA_WIDTH-1:0] op_imm_q, op_imm_d;
  logic [1:0]              rem_q, rem_d;

  logic [DATA_WIDTH-1:0]   ip;
  logic [1:0]              raw_len;
  logic [1:0]              imm_sel;
  dec_state_t              after_op;

  reg_tap #(
    .REGBUS_WIDTH (REGBUS_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH)
  ) u_ip_tap (
    .reg_line (reg_line),
    .idx      (IP_REG_IDX),
    .data     (ip)
  );

  assign raw_len  = insr[LEN_MSB:LEN_LSB];
  // Immediates fill imm0 then imm1: bytes already taken = len - remaining.
  assign imm_sel  = op_len_q - rem_q;
  assign after_op = run ? FETCH_OP : IDLE;

  always_comb begin
    state_d   = state_q;
    op_code_d = op_code_q;
    op_len_d  = op_len_q;
    op_imm_d  = op_imm_q;
    rem_d     = rem_q;
    fetch     = 1'b0;
    ip_we     = 1'b0;
    ip_wdata  = '0;
    op_valid  = 1'b0;
    op_trap   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (run) state_d = FETCH_OP;
      end

      FETCH_OP: begin
        fetch = 1'b1;
        if (flush) begin
          // A byte arriving with the flush is simply dropped; otherwise the
          // outstanding fetch must be drained first.
          state_d = load_en ? after_op : DRAIN;
        end else if (load_en) begin
          ip_we     = 1'b1;
          ip_wdata  = ip + DATA_WIDTH'(1);
          op_code_d = insr[5:0];
          op_imm_d  = '0;
          if (raw_len == LEN_ILLEGAL) begin
`ifdef MX11_ILLEGAL_TRAP_EN
            op_len_d = raw_len;
            rem_d    = 2'd0;
            state_d  = TRAP;
`else
            op_len_d = 2'd2;
            rem_d    = 2'd2;
            state_d  = SETTLE;
`endif
          end else begin
            op_len_d = raw_len;
            rem_d    = raw_len;
            state_d  = SETTLE;
          end
        end
      end

      FETCH_IMM: begin
        fetch = 1'b1;
        if (flush) begin
          state_d = load_en ? after_op : DRAIN;
        end else if (load_en) begin
          ip_we    = 1'b1;
          ip_wdata = ip + DATA_WIDTH'(1);
          if (imm_sel[0]) op_imm_d[2*DATA_WIDTH-1:DATA_WIDTH] = insr;
          else            op_imm_d[DATA_WIDTH-1:0]            = insr;
          rem_d   = rem_q - 2'd1;
          state_d = SETTLE;
        end
      end

      SETTLE: begin
        if (flush)             state_d = after_op;
        else if (rem_q != 2'd0) state_d = FETCH_IMM;
        else                   state_d = ISSUE;
      end

      ISSUE: begin
        op_valid = 1'b1;
        if (flush || op_ready) state_d = after_op;
      end

      DRAIN: begin
        if (load_en) state_d = after_op;
      end

      TRAP: begin
`ifdef MX11_ILLEGAL_TRAP_EN
        op_trap = 1'b1;
`endif
        if (flush) state_d = after_op;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      op_code_q <= '0;
      op_len_q  <= '0;
      op_imm_q  <= '0;
      rem_q     <= '0;
    end else begin
      state_q   <= state_d;
      op_code_q <= op_code_d;
      op_len_q  <= op_len_d;
      op_imm_q  <= op_imm_d;
      rem_q     <= rem_d;
    end
  end

  assign op_code = op_code_q;
  assign op_len  = op_len_q;
  assign op_imm  = op_imm_q;

endmodule
